// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data cache memory arbiter.
//   state_t : transaction FSM encodings (IDLE/ISSUE/WAIT/RESP)
//   owner_t : which requester currently owns the memory port (NONE/I/D)
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 6;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select between the I-cache and D-cache requests.
// Configuration macro: MEM_ARB_RR_EN
//   defined   : round-robin; on a tie the requester that did not own last wins
//   undefined : fixed priority, D-cache over I-cache (last_owner port absent)
// Ports:
//   i_req, d_req : pending requests
//   last_owner   : previous grant (round-robin build only)
//   grant_c      : selected owner, OWN_NONE when nobody requests
module mem_arbiter_pick
   import mem_arbiter_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
`ifdef MEM_ARB_RR_EN
   input  owner_t last_owner,
`endif
   output owner_t grant_c
);

   always_comb begin
      grant_c = OWN_NONE;
`ifdef MEM_ARB_RR_EN
      if (i_req && d_req) begin
         grant_c = (last_owner == OWN_D) ? OWN_I : OWN_D;
      end else if (d_req) begin
         grant_c = OWN_D;
      end else if (i_req) begin
         grant_c = OWN_I;
      end
`else
      if (d_req) begin
         grant_c = OWN_D;
      end else if (i_req) begin
         grant_c = OWN_I;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the read-only I-cache and the read/write D-cache.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Configuration macro: MEM_ARB_RR_EN (round-robin instead of fixed D-over-I priority).
// Ports:
//   CLK, RESET                        : clock, asynchronous active-low reset
//   i_read/i_address                  : I-cache fetch request (held until i_busywait low)
//   i_readdata/i_busywait             : I-cache response and stall
//   d_read/d_write/d_address/d_writedata : D-cache fetch / write-back request
//   d_readdata/d_busywait             : D-cache response and stall
//   mem_read/mem_write/mem_address/mem_writedata : registered command to memory
//   mem_readdata/mem_busywait         : memory response
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [DATA_W-1:0] i_readdata,
   output logic              i_busywait,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [DATA_W-1:0] d_writedata,
   output logic [DATA_W-1:0] d_readdata,
   output logic              d_busywait,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_busywait
);

   state_t            state, state_n;
   owner_t            owner, owner_n;
   owner_t            grant_c;
   logic              load_c, capture_c;
   logic              cmd_read, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [DATA_W-1:0] i_rdata, d_rdata;
   logic              d_req;

   assign d_req = d_read || d_write;

`ifdef MEM_ARB_RR_EN
   owner_t last_owner;

   // Remember who was granted last so a tie goes to the other side.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         last_owner <= OWN_I;
      end else if (load_c) begin
         last_owner <= grant_c;
      end
   end

   mem_arbiter_pick u_pick (
      .i_req      (i_read),
      .d_req      (d_req),
      .last_owner (last_owner),
      .grant_c    (grant_c)
   );
`else
   mem_arbiter_pick u_pick (
      .i_req   (i_read),
      .d_req   (d_req),
      .grant_c (grant_c)
   );
`endif

   // FSM state and owner registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= ST_IDLE;
         owner <= OWN_NONE;
      end else begin
         state <= state_n;
         owner <= owner_n;
      end
   end

   // Next-state: ISSUE always lasts one cycle because memory may raise busywait late.
   always_comb begin
      state_n   = state;
      owner_n   = owner;
      load_c    = 1'b0;
      capture_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_c != OWN_NONE) begin
               state_n = ST_ISSUE;
               owner_n = grant_c;
               load_c  = 1'b1;
            end
         end
         ST_ISSUE: state_n = ST_WAIT;
         ST_WAIT: begin
            if (!mem_busywait) begin
               state_n   = ST_RESP;
               capture_c = 1'b1;
            end
         end
         ST_RESP: begin
            state_n = ST_IDLE;
            owner_n = OWN_NONE;
         end
         default: begin
            state_n = ST_IDLE;
            owner_n = OWN_NONE;
         end
      endcase
   end

   // Command latch at grant; a D request with both read and write is a write.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cmd_read  <= 1'b0;
         cmd_write <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (load_c) begin
         if (grant_c == OWN_D) begin
            cmd_read  <= d_read && !d_write;
            cmd_write <= d_write;
            cmd_addr  <= d_address;
            cmd_wdata <= d_writedata;
         end else begin
            cmd_read  <= 1'b1;
            cmd_write <= 1'b0;
            cmd_addr  <= i_address;
            cmd_wdata <= '0;
         end
      end
   end

   // Read data capture into the owner's return register; writes leave it untouched.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         i_rdata <= '0;
         d_rdata <= '0;
      end else if (capture_c && cmd_read) begin
         if (owner == OWN_I) begin
            i_rdata <= mem_readdata;
         end else if (owner == OWN_D) begin
            d_rdata <= mem_readdata;
         end
      end
   end

   // Memory command is decoded from registers and state only.
   assign mem_read      = cmd_read  && ((state == ST_ISSUE) || (state == ST_WAIT));
   assign mem_write     = cmd_write && ((state == ST_ISSUE) || (state == ST_WAIT));
   assign mem_address   = cmd_addr;
   assign mem_writedata = cmd_wdata;

   assign i_readdata = i_rdata;
   assign d_readdata = d_rdata;

   // Stall every requester except the owner during its RESP cycle; forced low in reset.
   assign i_busywait = RESET && i_read && !((state == ST_RESP) && (owner == OWN_I));
   assign d_busywait = RESET && d_req  && !((state == ST_RESP) && (owner == OWN_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; outputs sampled on the falling edge.
module tb_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        i_read;
   logic [5:0]  i_address;
   logic [31:0] i_readdata;
   logic        i_busywait;
   logic        d_read;
   logic        d_write;
   logic [5:0]  d_address;
   logic [31:0] d_writedata;
   logic [31:0] d_readdata;
   logic        d_busywait;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   mem_arbiter dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .i_read        (i_read),
      .i_address     (i_address),
      .i_readdata    (i_readdata),
      .i_busywait    (i_busywait),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_address     (d_address),
      .d_writedata   (d_writedata),
      .d_readdata    (d_readdata),
      .d_busywait    (d_busywait),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
   );

   task automatic clear_inputs();
      i_read = 1'b0; i_address = '0;
      d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;
      mem_readdata = '0; mem_busywait = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      clear_inputs();
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      RESET = 1'b0;
      i_read = 1'b1;
      d_write = 1'b1;
      @(negedge CLK); @(negedge CLK);
      n_checks++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read got %0b exp 0", mem_read); else n_pass++;
      n_checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %0b exp 0", mem_write); else n_pass++;
      n_checks++; if (mem_address !== 6'h00) $display("FAIL rst_mem_address got %h exp 00", mem_address); else n_pass++;
      n_checks++; if (mem_writedata !== 32'h0) $display("FAIL rst_mem_writedata got %h exp 0", mem_writedata); else n_pass++;
      n_checks++; if (i_busywait !== 1'b0) $display("FAIL rst_i_busywait got %0b exp 0", i_busywait); else n_pass++;
      n_checks++; if (d_busywait !== 1'b0) $display("FAIL rst_d_busywait got %0b exp 0", d_busywait); else n_pass++;
      n_checks++; if (i_readdata !== 32'h0) $display("FAIL rst_i_readdata got %h exp 0", i_readdata); else n_pass++;
      n_checks++; if (d_readdata !== 32'h0) $display("FAIL rst_d_readdata got %h exp 0", d_readdata); else n_pass++;
      clear_inputs();
      RESET = 1'b1;
   endtask

   task automatic test_i_only();
      @(negedge CLK);
      i_read = 1'b1; i_address = 6'h05;
      @(negedge CLK); // ISSUE
      n_checks++; if (mem_read !== 1'b1) $display("FAIL i_issue_mem_read got %0b exp 1", mem_read); else n_pass++;
      n_checks++; if (mem_write !== 1'b0) $display("FAIL i_issue_mem_write got %0b exp 0", mem_write); else n_pass++;
      n_checks++; if (mem_address !== 6'h05) $display("FAIL i_issue_addr got %h exp 05", mem_address); else n_pass++;
      n_checks++; if (i_busywait !== 1'b1) $display("FAIL i_issue_busywait got %0b exp 1", i_busywait); else n_pass++;
      mem_busywait = 1'b1;
      @(negedge CLK); // WAIT (busywait ignored in ISSUE)
      @(negedge CLK); // wait cycle 1
      @(negedge CLK); // wait cycle 2
      n_checks++; if (mem_read !== 1'b1) $display("FAIL i_wait_mem_read got %0b exp 1", mem_read); else n_pass++;
      n_checks++; if (i_busywait !== 1'b1) $display("FAIL i_wait_busywait got %0b exp 1", i_busywait); else n_pass++;
      mem_busywait = 1'b0; mem_readdata = 32'hDEADBEEF;
      @(negedge CLK); // RESP
      n_checks++; if (i_busywait !== 1'b0) $display("FAIL i_resp_busywait got %0b exp 0", i_busywait); else n_pass++;
      n_checks++; if (i_readdata !== 32'hDEADBEEF) $display("FAIL i_resp_readdata got %h exp deadbeef", i_readdata); else n_pass++;
      n_checks++; if (mem_read !== 1'b0) $display("FAIL i_resp_mem_read got %0b exp 0", mem_read); else n_pass++;
      i_read = 1'b0; mem_readdata = '0;
      @(negedge CLK); // IDLE
      n_checks++; if (mem_read !== 1'b0) $display("FAIL i_idle_mem_read got %0b exp 0", mem_read); else n_pass++;
      n_checks++; if (i_readdata !== 32'hDEADBEEF) $display("FAIL i_idle_readdata got %h exp deadbeef", i_readdata); else n_pass++;
   endtask

   task automatic test_d_write();
      @(negedge CLK);
      d_write = 1'b1; d_address = 6'h0A; d_writedata = 32'h12345678;
      @(negedge CLK); // ISSUE
      n_checks++; if (mem_write !== 1'b1) $display("FAIL dw_issue_mem_write got %0b exp 1", mem_write); else n_pass++;
      n_checks++; if (mem_read !== 1'b0) $display("FAIL dw_issue_mem_read got %0b exp 0", mem_read); else n_pass++;
      n_checks++; if (mem_address !== 6'h0A) $display("FAIL dw_issue_addr got %h exp 0a", mem_address); else n_pass++;
      n_checks++; if (mem_writedata !== 32'h12345678) $display("FAIL dw_issue_wdata got %h exp 12345678", mem_writedata); else n_pass++;
      @(negedge CLK); // WAIT
      n_checks++; if (d_busywait !== 1'b1) $display("FAIL dw_wait_busywait got %0b exp 1", d_busywait); else n_pass++;
      n_checks++; if (mem_read !== 1'b0) $display("FAIL dw_wait_mem_read got %0b exp 0", mem_read); else n_pass++;
      mem_readdata = 32'hFFFFFFFF;
      @(negedge CLK); // RESP
      n_checks++; if (d_busywait !== 1'b0) $display("FAIL dw_resp_busywait got %0b exp 0", d_busywait); else n_pass++;
      n_checks++; if (mem_write !== 1'b0) $display("FAIL dw_resp_mem_write got %0b exp 0", mem_write); else n_pass++;
      d_write = 1'b0; mem_readdata = '0;
      @(negedge CLK); // IDLE
      n_checks++; if (d_readdata !== 32'h0) $display("FAIL dw_readdata got %h exp 0", d_readdata); else n_pass++;
   endtask

   task automatic test_both_fixed();
      pulse_reset();
      i_read = 1'b1; i_address = 6'h01;
      d_read = 1'b1; d_address = 6'h02;
      @(negedge CLK); // ISSUE for D
      n_checks++; if (mem_address !== 6'h02) $display("FAIL both_first_addr got %h exp 02", mem_address); else n_pass++;
      n_checks++; if (mem_read !== 1'b1) $display("FAIL both_first_mem_read got %0b exp 1", mem_read); else n_pass++;
      n_checks++; if (i_busywait !== 1'b1) $display("FAIL both_issue_i_busywait got %0b exp 1", i_busywait); else n_pass++;
      @(negedge CLK); // WAIT
      n_checks++; if (i_busywait !== 1'b1) $display("FAIL both_wait_i_busywait got %0b exp 1", i_busywait); else n_pass++;
      mem_readdata = 32'hA5A50002;
      @(negedge CLK); // RESP for D
      n_checks++; if (d_busywait !== 1'b0) $display("FAIL both_d_resp_busywait got %0b exp 0", d_busywait); else n_pass++;
      n_checks++; if (i_busywait !== 1'b1) $display("FAIL both_resp_i_busywait got %0b exp 1", i_busywait); else n_pass++;
      n_checks++; if (d_readdata !== 32'hA5A50002) $display("FAIL both_d_readdata got %h exp a5a50002", d_readdata); else n_pass++;
      d_read = 1'b0; mem_readdata = '0;
      @(negedge CLK); // IDLE
      n_checks++; if (mem_read !== 1'b0) $display("FAIL both_idle_mem_read got %0b exp 0", mem_read); else n_pass++;
      n_checks++; if (i_busywait !== 1'b1) $display("FAIL both_idle_i_busywait got %0b exp 1", i_busywait); else n_pass++;
      @(negedge CLK); // ISSUE for I
      n_checks++; if (mem_address !== 6'h01) $display("FAIL both_second_addr got %h exp 01", mem_address); else n_pass++;
      n_checks++; if (mem_read !== 1'b1) $display("FAIL both_second_mem_read got %0b exp 1", mem_read); else n_pass++;
      @(negedge CLK); // WAIT
      mem_readdata = 32'h00000001;
      @(negedge CLK); // RESP for I
      n_checks++; if (i_busywait !== 1'b0) $display("FAIL both_i_resp_busywait got %0b exp 0", i_busywait); else n_pass++;
      n_checks++; if (i_readdata !== 32'h00000001) $display("FAIL both_i_readdata got %h exp 00000001", i_readdata); else n_pass++;
      n_checks++; if (d_readdata !== 32'hA5A50002) $display("FAIL both_d_readdata_hold got %h exp a5a50002", d_readdata); else n_pass++;
      i_read = 1'b0; mem_readdata = '0;
      @(negedge CLK);
   endtask

   task automatic test_continuous();
      logic       found;
      logic       prev;
      logic [5:0] exp_addr;
      pulse_reset();
      i_read = 1'b1; i_address = 6'h01;
      d_read = 1'b1; d_address = 6'h02;
      mem_readdata = 32'h55AA55AA;
      for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
         exp_addr = ((g % 2) == 0) ? 6'h02 : 6'h01;
`else
         exp_addr = 6'h02;
`endif
         found = 1'b0;
         prev  = mem_read;
         for (int k = 0; k < 8 && !found; k++) begin
            @(negedge CLK);
            if (mem_read && !prev) found = 1'b1;
            else prev = mem_read;
         end
         n_checks++; if (!found) $display("FAIL cont_grant%0d_timeout got none exp grant", g); else n_pass++;
         n_checks++; if (mem_address !== exp_addr) $display("FAIL cont_grant%0d_addr got %h exp %h", g, mem_address, exp_addr); else n_pass++;
      end
      // Drop both requests mid-transaction; it must still finish and release the port.
      i_read = 1'b0; d_read = 1'b0;
      for (int k = 0; k < 4; k++) @(negedge CLK);
      n_checks++; if (mem_read !== 1'b0) $display("FAIL cont_drain_mem_read got %0b exp 0", mem_read); else n_pass++;
      n_checks++; if (d_busywait !== 1'b0) $display("FAIL cont_drain_d_busywait got %0b exp 0", d_busywait); else n_pass++;
      mem_readdata = '0;
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      d_read = 1'b1; d_address = 6'h2C;
      @(negedge CLK); // ISSUE
      mem_busywait = 1'b1;
      @(negedge CLK); // WAIT
      @(negedge CLK); // still WAIT
      n_checks++; if (mem_read !== 1'b1) $display("FAIL rmid_pre_mem_read got %0b exp 1", mem_read); else n_pass++;
      #1 RESET = 1'b0;
      #1;
      n_checks++; if (mem_read !== 1'b0) $display("FAIL rmid_mem_read got %0b exp 0", mem_read); else n_pass++;
      n_checks++; if (mem_address !== 6'h00) $display("FAIL rmid_mem_address got %h exp 00", mem_address); else n_pass++;
      n_checks++; if (d_busywait !== 1'b0) $display("FAIL rmid_d_busywait got %0b exp 0", d_busywait); else n_pass++;
      @(negedge CLK);
      RESET = 1'b1; mem_busywait = 1'b0;
      @(negedge CLK); // re-issued from ISSUE
      n_checks++; if (mem_read !== 1'b1) $display("FAIL rmid_reissue_mem_read got %0b exp 1", mem_read); else n_pass++;
      n_checks++; if (mem_address !== 6'h2C) $display("FAIL rmid_reissue_addr got %h exp 2c", mem_address); else n_pass++;
      n_checks++; if (d_busywait !== 1'b1) $display("FAIL rmid_reissue_busywait got %0b exp 1", d_busywait); else n_pass++;
      @(negedge CLK); // WAIT
      mem_readdata = 32'h0BADF00D;
      @(negedge CLK); // RESP
      n_checks++; if (d_readdata !== 32'h0BADF00D) $display("FAIL rmid_d_readdata got %h exp 0badf00d", d_readdata); else n_pass++;
      d_read = 1'b0; mem_readdata = '0;
      @(negedge CLK);
   endtask

   task automatic test_read_write_both();
      pulse_reset();
      d_read = 1'b1; d_write = 1'b1; d_address = 6'h3F; d_writedata = 32'hCAFE0001;
      mem_readdata = 32'hFFFFFFFF;
      @(negedge CLK); // ISSUE
      n_checks++; if (mem_write !== 1'b1) $display("FAIL rw_mem_write got %0b exp 1", mem_write); else n_pass++;
      n_checks++; if (mem_read !== 1'b0) $display("FAIL rw_mem_read got %0b exp 0", mem_read); else n_pass++;
      n_checks++; if (mem_address !== 6'h3F) $display("FAIL rw_addr got %h exp 3f", mem_address); else n_pass++;
      @(negedge CLK); // WAIT
      @(negedge CLK); // RESP
      n_checks++; if (d_busywait !== 1'b0) $display("FAIL rw_resp_busywait got %0b exp 0", d_busywait); else n_pass++;
      n_checks++; if (d_readdata !== 32'h0) $display("FAIL rw_d_readdata got %h exp 0", d_readdata); else n_pass++;
      d_read = 1'b0; d_write = 1'b0; mem_readdata = '0;
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_i_only();
      test_d_write();
      test_both_fixed();
      test_continuous();
      test_reset_mid();
      test_read_write_both();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
